// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
//
// Shares a single-ported, fixed-latency instruction memory between the
// instruction-fetch unit and the program loader/debug port. Only one
// transaction is in flight at a time. Ties are broken round-robin, so neither
// requester can starve the other. Misaligned or out-of-range addresses are
// answered with an error response and never reach the memory.
//
// Parameters
//   LAT      memory read latency in cycles (>= 1); mem_rdata is valid LAT
//            cycles after the mem_en cycle
//   MemSize  memory depth in 32-bit words; legal byte addresses are
//            0 .. MemSize*4-4, word aligned
//
// Ports
//   CLK, resetl                 clock (rising edge), async active-low reset
//   if_req/if_addr/if_flush     fetch request, byte address, response discard
//   if_gnt/if_valid/if_data/if_err
//                               fetch grant (comb), response pulse, data, error
//   ld_req/ld_we/ld_addr/ld_wdata
//                               loader request, write enable, address, data
//   ld_gnt/ld_done/ld_rdata/ld_err
//                               loader grant (comb), completion pulse, data, error
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata
//                               memory strobe, write, address, write/read data
//   busy                        a transaction is in progress
// -----------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int LAT     = 2,
    parameter int MemSize = 40
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_data,
    output logic        if_err,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [63:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_gnt,
    output logic        ld_done,
    output logic [31:0] ld_rdata,
    output logic        ld_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [63:0] ADDR_LIMIT = 64'(MemSize) * 64'd4;
    localparam int          CNT_W      = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Word aligned and inside the array; the compare is a full 64-bit unsigned one.
    function automatic logic addr_legal(input logic [63:0] addr);
        return (addr[1:0] == 2'b00) && (addr < ADDR_LIMIT);
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               last_ld_r;     // 1: loader held the most recent grant
    logic               owner_ld_r;    // 1: in-flight transaction belongs to the loader
    logic               we_r;          // in-flight transaction is a loader write
    logic               flushed_r;     // in-flight fetch has seen if_flush
    logic               grant_if_s;
    logic               grant_ld_s;
    logic               grant_any_s;
    logic [63:0]        sel_addr_s;
    logic               sel_legal_s;
    logic               resp_s;
    logic               resp_err_s;

    logic               if_valid_r;
    logic [31:0]        if_data_r;
    logic               if_err_r;
    logic               ld_done_r;
    logic [31:0]        ld_rdata_r;
    logic               ld_err_r;
    logic               mem_en_r;
    logic               mem_we_r;
    logic [63:0]        mem_addr_r;
    logic [31:0]        mem_wdata_r;
    logic               busy_r;

    // Round-robin grant; only in IDLE and never while reset is asserted.
    always_comb begin
        grant_if_s = 1'b0;
        grant_ld_s = 1'b0;
        if ((state_r == ST_IDLE) && resetl) begin
            if (if_req && (!ld_req || last_ld_r)) begin
                grant_if_s = 1'b1;
            end else if (ld_req) begin
                grant_ld_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
                grant_ld_s = 1'b0;
            end
        end else begin
            grant_if_s = 1'b0;
            grant_ld_s = 1'b0;
        end
    end

    // Address of the request being granted and its legality.
    always_comb begin
        sel_addr_s = if_addr;
        if (grant_ld_s) begin
            sel_addr_s = ld_addr;
        end else begin
            sel_addr_s = if_addr;
        end
        sel_legal_s = addr_legal(sel_addr_s);
        grant_any_s = grant_if_s | grant_ld_s;
    end

    // The counter is loaded with LAT in ISSUE and the read data is taken on the
    // WAIT cycle where it steps from 1 to 0, i.e. the end of mem_en cycle + LAT.
    assign resp_err_s = (state_r == ST_ERR);
    assign resp_s     = ((state_r == ST_WAIT) && (cnt_r == CNT_ONE)) || resp_err_s;

    // FSM state register.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_any_s) begin
                    next_state_s = sel_legal_s ? ST_ISSUE : ST_ERR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (cnt_r == CNT_ONE) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_ERR:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Latency counter.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            cnt_r <= CNT_ZERO;
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= CNT_LOAD;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= CNT_ZERO;
        end
    end

    // Request capture at grant and the one-cycle memory strobe that follows.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            last_ld_r   <= 1'b1;
            owner_ld_r  <= 1'b0;
            we_r        <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 64'd0;
            mem_wdata_r <= 32'd0;
        end else begin
            mem_en_r <= grant_any_s & sel_legal_s;
            mem_we_r <= grant_ld_s & ld_we & sel_legal_s;
            if (grant_any_s) begin
                last_ld_r  <= grant_ld_s;
                owner_ld_r <= grant_ld_s;
                we_r       <= grant_ld_s & ld_we;
                mem_addr_r <= sel_addr_s;
            end else begin
                last_ld_r  <= last_ld_r;
                owner_ld_r <= owner_ld_r;
                we_r       <= we_r;
                mem_addr_r <= mem_addr_r;
            end
            if (grant_ld_s) begin
                mem_wdata_r <= ld_wdata;
            end else begin
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Sticky flush marker for the in-flight fetch, starting at its grant cycle.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            flushed_r <= 1'b0;
        end else if (grant_if_s) begin
            flushed_r <= if_flush;
        end else if (grant_ld_s) begin
            flushed_r <= 1'b0;
        end else if ((state_r != ST_IDLE) && !owner_ld_r) begin
            flushed_r <= flushed_r | if_flush;
        end else begin
            flushed_r <= flushed_r;
        end
    end

    // Response registers: pulses last one cycle, data/err hold until the next response.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            if_valid_r <= 1'b0;
            if_data_r  <= 32'd0;
            if_err_r   <= 1'b0;
            ld_done_r  <= 1'b0;
            ld_rdata_r <= 32'd0;
            ld_err_r   <= 1'b0;
        end else begin
            if_valid_r <= 1'b0;
            ld_done_r  <= 1'b0;
            if (resp_s && owner_ld_r) begin
                ld_done_r  <= 1'b1;
                ld_rdata_r <= (resp_err_s || we_r) ? 32'd0 : mem_rdata;
                ld_err_r   <= resp_err_s;
            end else if (resp_s && !(flushed_r || if_flush)) begin
                if_valid_r <= 1'b1;
                if_data_r  <= resp_err_s ? 32'd0 : mem_rdata;
                if_err_r   <= resp_err_s;
            end else begin
                if_data_r  <= if_data_r;
                if_err_r   <= if_err_r;
                ld_rdata_r <= ld_rdata_r;
                ld_err_r   <= ld_err_r;
            end
        end
    end

    // Busy flag, aligned with the state register.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != ST_IDLE);
        end
    end

    assign if_gnt    = grant_if_s;
    assign ld_gnt    = grant_ld_s;
    // A flush raised in the response cycle itself still has to hide that response.
    assign if_valid  = if_valid_r & ~if_flush;
    assign if_err    = if_err_r & ~(if_valid_r & if_flush);
    assign if_data   = if_data_r;
    assign ld_done   = ld_done_r;
    assign ld_rdata  = ld_rdata_r;
    assign ld_err    = ld_err_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_port_arbiter
//
// Directed bench for imem_port_arbiter (LAT=2, MemSize=40). A behavioural
// instruction memory answers reads exactly LAT cycles after mem_en and drives
// a poison value otherwise. A table of single transactions is applied in a
// loop; tie arbitration, grant-in-response-cycle and reset during an access
// are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_imem_port_arbiter;

    localparam int TB_LAT = 2;

    logic        CLK;
    logic        resetl;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_data;
    logic        if_err;
    logic        ld_req;
    logic        ld_we;
    logic [63:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic        ld_done;
    logic [31:0] ld_rdata;
    logic        ld_err;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks;
    int failures;

    imem_port_arbiter #(.LAT(TB_LAT), .MemSize(40)) dut (
        .CLK(CLK), .resetl(resetl),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_valid(if_valid), .if_data(if_data), .if_err(if_err),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural memory ----------------
    logic [31:0] mem [0:63];
    logic [31:0] dpipe [0:TB_LAT-1];
    logic [TB_LAT-1:0] vpipe;
    bit          mem_loaded;
    logic [5:0]  midx;
    logic        mok;

    assign midx      = mem_addr[7:2];
    assign mok       = (mem_addr < 64'd160);
    assign mem_rdata = vpipe[TB_LAT-1] ? dpipe[TB_LAT-1] : 32'hDEAD_BEEF;

    // Word 0 holds 0xF84003E9, every other word i holds 0x91000000 | (i*4).
    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= (i == 0) ? 32'hF840_03E9 : (32'h9100_0000 | 32'(i * 4));
            end
            mem_loaded <= 1'b1;
        end else if (mem_en && mem_we && mok) begin
            mem[midx] <= mem_wdata;
        end
        vpipe[0] <= mem_en && !mem_we && mok;
        dpipe[0] <= mem[midx];
        for (int i = 1; i < TB_LAT; i++) begin
            vpipe[i] <= vpipe[i-1];
            dpipe[i] <= dpipe[i-1];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        bit          is_ld;
        bit          we;
        logic [63:0] addr;
        logic [31:0] wdata;
        bit          flush;
        bit          exp_err;
        logic [31:0] exp_data;
    } txn_t;

    txn_t tbl [14];

    // Runs one transaction from an idle DUT; entered and left at posedge+1.
    task automatic run_txn(input int id, input txn_t t);
        bit found;
        int resp_k;
        int npulse;
        int nmem_en;
        int end_k;
        logic [31:0] rdata;
        logic rerr;
        logic pulse;
        found   = 1'b0;
        resp_k  = 0;
        npulse  = 0;
        nmem_en = 0;
        rdata   = 32'd0;
        rerr    = 1'b0;
        end_k   = t.exp_err ? 2 : TB_LAT + 2;
        if (t.is_ld) begin
            ld_req = 1'b1; ld_we = t.we; ld_addr = t.addr; ld_wdata = t.wdata;
        end else begin
            if_req = 1'b1; if_addr = t.addr;
        end
        @(negedge CLK);
        found = t.is_ld ? ld_gnt : if_gnt;
        chk($sformatf("txn%0d_gnt", id), {63'd0, found}, 64'd1);
        chk($sformatf("txn%0d_other_gnt", id), {63'd0, (t.is_ld ? if_gnt : ld_gnt)}, 64'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin
                if_req = 1'b0; ld_req = 1'b0;
                ld_addr = 64'h0BAD_0BAD; if_addr = 64'h0BAD_0BAD; ld_wdata = 32'h5555_5555;
            end
            if_flush = t.flush && (k == 2);
            @(negedge CLK);
            if (mem_en) nmem_en++;
            if (k == 1 && !t.exp_err) begin
                chk($sformatf("txn%0d_mem_addr", id), mem_addr, t.addr);
                chk($sformatf("txn%0d_mem_we", id), {63'd0, mem_we}, {63'd0, (t.is_ld && t.we)});
                if (t.we) chk($sformatf("txn%0d_mem_wdata", id), {32'd0, mem_wdata}, {32'd0, t.wdata});
            end
            if (k == 1) chk($sformatf("txn%0d_busy_on", id), {63'd0, busy}, 64'd1);
            if (k == end_k) chk($sformatf("txn%0d_busy_off", id), {63'd0, busy}, 64'd0);
            pulse = t.is_ld ? ld_done : if_valid;
            if (pulse) begin
                npulse++;
                if (resp_k == 0) begin
                    resp_k = k;
                    rdata  = t.is_ld ? ld_rdata : if_data;
                    rerr   = t.is_ld ? ld_err : if_err;
                end
            end
        end
        if_flush = 1'b0;
        chk($sformatf("txn%0d_mem_en_count", id), 64'(nmem_en), t.exp_err ? 64'd0 : 64'd1);
        chk($sformatf("txn%0d_pulses", id), 64'(npulse), (t.flush && !t.is_ld) ? 64'd0 : 64'd1);
        if (npulse > 0) begin
            chk($sformatf("txn%0d_latency", id), 64'(resp_k), 64'(end_k));
            chk($sformatf("txn%0d_data", id), {32'd0, rdata}, {32'd0, t.exp_data});
            chk($sformatf("txn%0d_err", id), {63'd0, rerr}, {63'd0, t.exp_err});
        end
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0; failures = 0;
        resetl = 1'b0;
        if_req = 1'b0; if_addr = 64'd0; if_flush = 1'b0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 64'd0; ld_wdata = 32'd0;

        //            is_ld we  addr                  wdata          flush err  data
        tbl[0]  = '{1'b0, 1'b0, 64'h000,           32'h0,          1'b0, 1'b0, 32'hF840_03E9};
        tbl[1]  = '{1'b0, 1'b0, 64'h004,           32'h0,          1'b0, 1'b0, 32'h9100_0004};
        tbl[2]  = '{1'b1, 1'b0, 64'h008,           32'h0,          1'b0, 1'b0, 32'h9100_0008};
        tbl[3]  = '{1'b1, 1'b1, 64'h034,           32'hCB09_0129,  1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 64'h034,           32'h0,          1'b0, 1'b0, 32'hCB09_0129};
        tbl[5]  = '{1'b0, 1'b0, 64'h006,           32'h0,          1'b0, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 64'h0A0,           32'h0,          1'b0, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 64'h09C,           32'h0,          1'b0, 1'b0, 32'h9100_009C};
        tbl[8]  = '{1'b0, 1'b0, 64'h1_0000_0000,   32'h0,          1'b0, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 64'h01C,           32'h0,          1'b1, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 64'h0A4,           32'h1234_5678,  1'b0, 1'b1, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 64'h034,           32'h0,          1'b0, 1'b0, 32'hCB09_0129};
        tbl[12] = '{1'b0, 1'b0, 64'h098,           32'h0,          1'b0, 1'b0, 32'h9100_0098};
        tbl[13] = '{1'b1, 1'b0, 64'h002,           32'h0,          1'b0, 1'b1, 32'h0};

        repeat (3) step();
        @(negedge CLK);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_ld_done", {63'd0, ld_done}, 64'd0);
        chk("rst_if_data", {32'd0, if_data}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        step();
        resetl = 1'b1;
        step();

        // Tie straight after reset: fetch first, loader in the fetch response cycle,
        // second tie in the loader response cycle goes to fetch again.
        if_req = 1'b1; if_addr = 64'h004;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 64'h008;
        @(negedge CLK);
        chk("tie1_if_gnt", {63'd0, if_gnt}, 64'd1);
        chk("tie1_ld_gnt", {63'd0, ld_gnt}, 64'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) if_req = 1'b0;
            if (k == 5) ld_req = 1'b0;
            if (k == 8) begin if_req = 1'b1; if_addr = 64'h000; ld_req = 1'b1; end
            if (k == 9) begin if_req = 1'b0; ld_req = 1'b0; end
            @(negedge CLK);
            if (k == 3) chk("tie1_ld_wait", {63'd0, ld_gnt}, 64'd0);
            if (k == 4) begin
                chk("tie1_if_valid", {63'd0, if_valid}, 64'd1);
                chk("tie1_if_data", {32'd0, if_data}, 64'h9100_0004);
                chk("tie1_ld_gnt_late", {63'd0, ld_gnt}, 64'd1);
            end
            if (k == 8) begin
                chk("tie1_ld_done", {63'd0, ld_done}, 64'd1);
                chk("tie1_ld_rdata", {32'd0, ld_rdata}, 64'h9100_0008);
                chk("tie2_if_gnt", {63'd0, if_gnt}, 64'd1);
                chk("tie2_ld_gnt", {63'd0, ld_gnt}, 64'd0);
            end
            if (k == 12) chk("tie2_if_data", {32'd0, if_data}, 64'hF840_03E9);
        end
        step();

        for (int i = 0; i < 14; i++) begin
            run_txn(i, tbl[i]);
        end

        // Reset during WAIT of a fetch: immediate zero outputs, no late response,
        // pointer back to "loader" so the next tie is won by fetch.
        if_req = 1'b1; if_addr = 64'h000;
        @(negedge CLK);
        chk("rstmid_gnt", {63'd0, if_gnt}, 64'd1);
        step();
        if_req = 1'b0;
        step();
        step();
        resetl = 1'b0;
        if_req = 1'b1;
        #1;
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_if_data", {32'd0, if_data}, 64'd0);
        chk("rstmid_ld_rdata", {32'd0, ld_rdata}, 64'd0);
        chk("rstmid_if_gnt", {63'd0, if_gnt}, 64'd0);
        step();
        if_req = 1'b0;
        step();
        resetl = 1'b1;
        begin
            int np;
            np = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge CLK);
                if (if_valid || ld_done || mem_en) np++;
                step();
            end
            chk("rstmid_no_resp", 64'(np), 64'd0);
        end
        if_req = 1'b1; if_addr = 64'h004;
        ld_req = 1'b1; ld_addr = 64'h008; ld_we = 1'b0;
        @(negedge CLK);
        chk("rstmid_tie_if_gnt", {63'd0, if_gnt}, 64'd1);
        chk("rstmid_tie_ld_gnt", {63'd0, ld_gnt}, 64'd0);
        step();
        if_req = 1'b0; ld_req = 1'b0;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
